// File: rtl/execute_stage_pkg.sv
// exec_pkg: opcode map, flag bit positions and FSM states shared by the RISC-Net execute stage.
package exec_pkg;

  localparam logic [7:0] OP_NOP = 8'h00;
  localparam logic [7:0] OP_ADD = 8'h01;
  localparam logic [7:0] OP_SUB = 8'h02;
  localparam logic [7:0] OP_AND = 8'h03;
  localparam logic [7:0] OP_OR  = 8'h04;
  localparam logic [7:0] OP_XOR = 8'h05;
  localparam logic [7:0] OP_SHL = 8'h06;
  localparam logic [7:0] OP_SHR = 8'h07;
  localparam logic [7:0] OP_MOV = 8'h08;
  localparam logic [7:0] OP_CMP = 8'h09;
  localparam logic [7:0] OP_MUL = 8'h0A;

  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

endpackage

// File: rtl/execute_stage_if.sv
// execute_stage_if: operand-fetch -> execute -> writeback handshake bundle.
interface execute_stage_if #(
  parameter int DATA_W = 16,
  parameter int OPC_W  = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [OPC_W-1:0]  in_opcode;
  logic [DATA_W-1:0] in_op1;
  logic [DATA_W-1:0] in_op2;
  logic              out_valid;
  logic              out_ready;
  logic [OPC_W-1:0]  out_opcode;
  logic [DATA_W-1:0] out_result;
  logic [3:0]        out_flags;
  logic              out_illegal;
  logic              busy;

  modport master (
    output in_valid, in_opcode, in_op1, in_op2, out_ready,
    input  in_ready, out_valid, out_opcode, out_result, out_flags, out_illegal, busy
  );

  modport slave (
    input  in_valid, in_opcode, in_op1, in_op2, out_ready,
    output in_ready, out_valid, out_opcode, out_result, out_flags, out_illegal, busy
  );
endinterface

// File: rtl/execute_stage_mul_iter.sv
// mul_iter: radix-2 shift-add unsigned multiplier, one partial product per clock, W iterations.
// done/product are valid during the final iteration so the caller can load on that same edge.
module mul_iter #(
  parameter int W = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           done,
  output logic [2*W-1:0] product
);
  localparam int CNT_W = $clog2(W);

  logic             run;
  logic [CNT_W-1:0] cnt;
  logic [2*W-1:0]   acc;
  logic [2*W-1:0]   mcand;
  logic [2*W-1:0]   acc_nx;
  logic [W-1:0]     mplier;

  assign acc_nx  = mplier[0] ? acc + mcand : acc;
  assign done    = run && (cnt == CNT_W'(W - 1));
  assign product = acc_nx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run <= 1'b0;
      cnt <= '0;
    end else if (start) begin
      run <= 1'b1;
      cnt <= '0;
    end else if (run) begin
      cnt <= cnt + 1'b1;
      if (done) run <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (start) begin
      acc    <= '0;
      mcand  <= {{W{1'b0}}, a};
      mplier <= b;
    end else if (run) begin
      acc    <= acc_nx;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
    end
  end

endmodule

// File: rtl/execute_stage.sv
// execute_stage: RISC-Net ALU stage with Z/N/C/V flag register and valid/ready result register.
// Define EXEC_MUL_EN to build the 16-iteration multiplier; otherwise opcode 0x0A decodes as illegal.
module execute_stage
  import exec_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int OPC_W  = 8
) (
  input logic            clk,
  input logic            rst,
  execute_stage_if.slave bus
);
  localparam int MSB = DATA_W - 1;

  function automatic logic add_ovf(input logic sa, input logic sb, input logic sr);
    return (sa == sb) && (sr != sa);
  endfunction

  function automatic logic sub_ovf(input logic sa, input logic sb, input logic sr);
    return (sa != sb) && (sr != sa);
  endfunction

  function automatic logic [3:0] pack_flags(input logic [DATA_W-1:0] v, input logic c, input logic o);
    logic [3:0] f;
    f         = '0;
    f[FLAG_Z] = (v == '0);
    f[FLAG_N] = v[MSB];
    f[FLAG_C] = c;
    f[FLAG_V] = o;
    return f;
  endfunction

  logic [DATA_W:0]   sum_p0, dif_p0, shl_p0, shr_p0;
  logic [DATA_W-1:0] res_p0, fval_p0;
  logic [3:0]        flags_p0;
  logic              c_p0, v_p0, wr_p0, ill_p0, mul_p0;

  logic              vld_p1, ill_p1;
  logic [OPC_W-1:0]  opcode_p1;
  logic [DATA_W-1:0] result_p1;
  logic [3:0]        flags_q;

  logic              idle, accept, ld;
  logic [OPC_W-1:0]  ld_opc;
  logic [DATA_W-1:0] ld_res;
  logic [3:0]        ld_flags;
  logic              ld_ill;

  assign bus.in_ready = idle && (!vld_p1 || bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;

  // p0: single-cycle ALU evaluated straight from the incoming operands
  always_comb begin
    sum_p0  = {1'b0, bus.in_op1} + {1'b0, bus.in_op2};
    dif_p0  = {1'b0, bus.in_op1} - {1'b0, bus.in_op2};
    shl_p0  = {1'b0, bus.in_op1} << bus.in_op2[3:0];
    shr_p0  = {bus.in_op1, 1'b0} >> bus.in_op2[3:0];
    res_p0  = '0;
    c_p0    = 1'b0;
    v_p0    = 1'b0;
    wr_p0   = 1'b1;
    ill_p0  = 1'b0;
    mul_p0  = 1'b0;
    case (bus.in_opcode)
      OPC_W'(OP_NOP): wr_p0 = 1'b0;
      OPC_W'(OP_ADD): begin
        res_p0 = sum_p0[MSB:0];
        c_p0   = sum_p0[DATA_W];
        v_p0   = add_ovf(bus.in_op1[MSB], bus.in_op2[MSB], sum_p0[MSB]);
      end
      OPC_W'(OP_SUB), OPC_W'(OP_CMP): begin
        res_p0 = (bus.in_opcode == OPC_W'(OP_CMP)) ? bus.in_op1 : dif_p0[MSB:0];
        c_p0   = dif_p0[DATA_W];
        v_p0   = sub_ovf(bus.in_op1[MSB], bus.in_op2[MSB], dif_p0[MSB]);
      end
      OPC_W'(OP_AND): res_p0 = bus.in_op1 & bus.in_op2;
      OPC_W'(OP_OR):  res_p0 = bus.in_op1 | bus.in_op2;
      OPC_W'(OP_XOR): res_p0 = bus.in_op1 ^ bus.in_op2;
      OPC_W'(OP_SHL): begin
        res_p0 = shl_p0[MSB:0];
        c_p0   = shl_p0[DATA_W];
      end
      OPC_W'(OP_SHR): begin
        res_p0 = shr_p0[DATA_W:1];
        c_p0   = shr_p0[0];
      end
      OPC_W'(OP_MOV): begin
        res_p0 = bus.in_op2;
        wr_p0  = 1'b0;
      end
`ifdef EXEC_MUL_EN
      OPC_W'(OP_MUL): begin
        mul_p0 = 1'b1;
        wr_p0  = 1'b0;
      end
`endif
      default: begin
        ill_p0 = 1'b1;
        wr_p0  = 1'b0;
      end
    endcase
    // CMP reports op1 but flags the difference
    fval_p0  = (bus.in_opcode == OPC_W'(OP_CMP)) ? dif_p0[MSB:0] : res_p0;
    flags_p0 = wr_p0 ? pack_flags(fval_p0, c_p0, v_p0) : flags_q;
  end

`ifdef EXEC_MUL_EN
  state_t              state, state_nx;
  logic                mul_start, mul_done;
  logic [2*DATA_W-1:0] mul_prod;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    mul_start = 1'b0;
    case (state)
      ST_IDLE: if (accept && mul_p0) begin
        state_nx  = ST_MUL;
        mul_start = 1'b1;
      end
      ST_MUL:  if (mul_done) state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  assign idle     = (state == ST_IDLE);
  assign bus.busy = (state == ST_MUL);

  mul_iter #(.W(DATA_W)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .a       (bus.in_op1),
    .b       (bus.in_op2),
    .done    (mul_done),
    .product (mul_prod)
  );
`else
  assign idle     = 1'b1;
  assign bus.busy = 1'b0;
`endif

  // p1 load select: finished multiply, else a freshly accepted single-cycle op
  always_comb begin
    ld       = accept && !mul_p0;
    ld_opc   = bus.in_opcode;
    ld_res   = res_p0;
    ld_flags = flags_p0;
    ld_ill   = ill_p0;
`ifdef EXEC_MUL_EN
    if (mul_done) begin
      ld       = 1'b1;
      ld_opc   = OPC_W'(OP_MUL);
      ld_res   = mul_prod[MSB:0];
      ld_flags = pack_flags(mul_prod[MSB:0], |mul_prod[2*DATA_W-1:DATA_W], 1'b0);
      ld_ill   = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1    <= 1'b0;
      opcode_p1 <= '0;
      result_p1 <= '0;
      ill_p1    <= 1'b0;
      flags_q   <= '0;
    end else if (ld) begin
      vld_p1    <= 1'b1;
      opcode_p1 <= ld_opc;
      result_p1 <= ld_res;
      ill_p1    <= ld_ill;
      flags_q   <= ld_flags;
    end else if (vld_p1 && bus.out_ready) begin
      vld_p1 <= 1'b0;
    end
  end

  assign bus.out_valid   = vld_p1;
  assign bus.out_opcode  = opcode_p1;
  assign bus.out_result  = result_p1;
  assign bus.out_flags   = flags_q;
  assign bus.out_illegal = ill_p1;

endmodule
